note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a programmable sequence of notes by driving the 12-bit `freq` input and a gate of the square-wave oscillator on the 1 MHz synth clock. Software or the front panel loads a small table of (frequency, duration) entries, then pulses `start`. The block steps through the table with millisecond timing, an inter-note gap and optional looping. It sits between the control/input logic and the oscillator, and it is the only writer of the oscillator's frequency.

## Interface
Parameters:
- `DEPTH`, 16: table entries; power of two.
- `CLK_HZ`, 1_000_000: clock frequency.
- `TICK_HZ`, 1000: duration unit rate. `TICK_DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `GAP_TICKS`, 10: silent ticks after every note.

Ports:
- `clk`  in  1: synth clock; one clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: table write strobe.
- `wr_addr`  in  log2(DEPTH): table write address.
- `wr_freq`  in  12: note frequency in Hz; 0 means rest.
- `wr_dur`  in  8: note duration in ticks; 0 means skip.
- `len`  in  log2(DEPTH)+1: number of entries to play, 0..DEPTH; sampled at `start`.
- `loop`  in  1: repeat from entry 0 after the last entry; sampled at each wrap.
- `start`  in  1: single-cycle start request.
- `stop`  in  1: single-cycle abort request.
- `busy`  out  1: high in every state except IDLE.
- `freq_out`  out  12: connects to the oscillator `freq`.
- `gate`  out  1: audio enable for the oscillator output.
- `step_idx`  out  log2(DEPTH): index of the current entry.
- `done`  out  1: single-cycle pulse when a non-looping sequence ends.

## Operation
- Table storage: DEPTH × 20-bit register array, not reset. Writes happen every cycle that `wr_en` is high, including while busy. An entry written during playback takes effect the next time that entry is loaded.
- States:
  - IDLE. On `start`, latch `len`. If `len == 0`, pulse `done` and stay in IDLE. Otherwise set idx = 0 and go to LOAD.
  - LOAD (1 cycle). Read entry[idx].
    - If dur == 0, advance without a gap.
    - Otherwise, if freq != 0, set `freq_out` to freq; if freq == 0, hold `freq_out`. Go to NOTE.
  - NOTE. `gate` = (freq != 0). Lasts dur × TICK_DIV cycles, then go to GAP.
  - GAP. `gate` = 0. Lasts GAP_TICKS × TICK_DIV cycles, then advance.
  - Advance. If idx+1 < `len`, increment idx and go to LOAD. Else if `loop`, set idx = 0 and go to LOAD. Else pulse `done` and go to IDLE.
- `freq_out` is never driven to 0, because the oscillator divides by it.
- `stop` wins over every other event in the same cycle:
  - Next state is IDLE, `gate` = 0.
  - `done` is not pulsed; `freq_out` holds its value; `step_idx` holds its value.
- `start` while busy is ignored. `start` together with `stop` in IDLE is ignored.
- The duration counter restarts at 0 on every NOTE or GAP entry. No partial-tick carry-over.

## Timing
- Reset values: `busy` = 0, `gate` = 0, `done` = 0, `step_idx` = 0, `freq_out` = 440, state IDLE. Counters are cleared.
- `start` sampled at edge N:
  - LOAD at N+1.
  - `gate` high and `freq_out` updated from edge N+2.
- All outputs are registered.
- Period of one non-skipped entry: 1 + (dur + GAP_TICKS) × TICK_DIV cycles.
- A skipped entry costs exactly 1 cycle (its LOAD).
- `done` rises the cycle after the last GAP cycle; `busy` falls in the same cycle.
- `stop` sampled at edge N: `gate` = 0 and `busy` = 0 from N+1.
- Reset asserted mid-sequence: all outputs return to their reset values immediately. Table contents are undefined after reset.

## Structure
- Shared package `synth_pkg`:
  - FREQ_W = 12, DUR_W = 8, DEFAULT_FREQ = 440.
  - State enum {IDLE, LOAD, NOTE, GAP}.
- Sub-module `tick_prescaler`: counts to TICK_DIV−1, emits a one-cycle `tick`, and has a synchronous `clr` input. It is instantiated once and cleared on every NOTE/GAP entry.
- The duration/gap down-counter and the index logic stay in the top level.

## Test plan
All scenarios use CLK_HZ = 1000, TICK_HZ = 100 (TICK_DIV = 10), GAP_TICKS = 2.
1. Reset mid-NOTE → next cycle: `freq_out` = 440, `gate` = 0, `busy` = 0, `step_idx` = 0.
2. Table {(440, 3), (880, 1)}, `len` = 2, `loop` = 0, `start` at cycle 0:
   - `gate` high during cycles 2–31 with `freq_out` = 440.
   - `gate` high during cycles 53–62 with `freq_out` = 880.
   - `done` at cycle 83; `busy` is 0 from cycle 83.
3. Entry (0, 2) between two 440 notes → `gate` stays low for 40 cycles; `freq_out` stays 440 throughout.
4. Entry with dur = 0 → that entry takes 1 cycle; `step_idx` passes through it; no gap is inserted.
5. `loop` = 1 with `len` = 2:
   - After entry 1's gap, `step_idx` wraps to 0 and no `done` pulse occurs.
   - Deasserting `loop` ends the sequence at the next wrap with a `done` pulse.
6. `stop` in NOTE → `gate` = 0 next cycle, no `done`. `start` while busy → no effect. `start` with `len` = 0 → `done` the next cycle and `busy` stays 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth datapath blocks.
package synth_pkg;
  localparam int FREQ_W = 12;
  localparam int DUR_W  = 8;
  localparam logic [FREQ_W-1:0] DEFAULT_FREQ = 12'd440;

  typedef enum logic [1:0] {IDLE, LOAD, NOTE, GAP} state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_t;
endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every DIV cycles; clr restarts the count.
module tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_sequencer.sv
// Steps through a (frequency, duration) table, driving the oscillator frequency and gate
// with tick-based note and gap timing, optional looping and an abort path.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CLK_HZ    = 1_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [FREQ_W-1:0]        wr_freq,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [FREQ_W-1:0]        freq_out,
  output logic                     gate,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     done
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = AW + 1;

  note_t tbl_q [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic          tick;
  logic          tick_clr;
  logic          advance;
  logic [LW-1:0] idx_nxt;
  note_t         entry;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Table is plain storage: no reset, writable at any time.
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_addr] <= '{freq: wr_freq, dur: wr_dur};
  end

  assign entry   = tbl_q[idx_q];
  assign idx_nxt = {1'b0, idx_q} + LW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    gate_d   = gate_q;
    done_d   = 1'b0;
    tick_clr = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      IDLE: begin
        gate_d = 1'b0;
        if (start && !stop) begin
          len_d = len;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (entry.dur == '0) begin
          advance = 1'b1;
        end else begin
          // A rest keeps the previous pitch so the oscillator never sees 0.
          if (entry.freq != '0) freq_d = entry.freq;
          gate_d   = (entry.freq != '0);
          cnt_d    = entry.dur;
          tick_clr = 1'b1;
          state_d  = NOTE;
        end
      end
      NOTE: begin
        if (tick) begin
          if (cnt_q == DUR_W'(1)) begin
            gate_d = 1'b0;
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              cnt_d    = DUR_W'(GAP_TICKS);
              tick_clr = 1'b1;
              state_d  = GAP;
            end
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == DUR_W'(1)) advance = 1'b1;
          else                    cnt_d   = cnt_q - DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      gate_d = 1'b0;
      if (idx_nxt < len_q) begin
        idx_d   = idx_nxt[AW-1:0];
        state_d = LOAD;
      end else if (loop) begin
        idx_d   = '0;
        state_d = LOAD;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    // Abort overrides everything decided above, freezing pitch and index.
    if (stop) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      done_d  = 1'b0;
      freq_d  = freq_q;
      idx_d   = idx_q;
      len_d   = len_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= DEFAULT_FREQ;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign freq_out = freq_q;
  assign gate     = gate_q;
  assign step_idx = idx_q;
  assign done     = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: note/done events are scoreboarded against a queue
// of expected (cycle, length, freq, index) records; point checks cover state in between.
module tb_note_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_freq = '0;
  logic [7:0]  wr_dur = '0;
  logic [4:0]  len = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, gate, done;
  logic [11:0] freq_out;
  logic [3:0]  step_idx;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int t0 = 0;

  typedef struct packed {
    logic [1:0]  kind;   // 1 = gated note, 2 = done pulse
    logic [31:0] c;
    logic [31:0] len;
    logic [11:0] freq;
    logic [3:0]  idx;
  } evt_t;

  evt_t exp_q[$];

  note_sequencer #(
    .DEPTH(16), .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
    .wr_dur(wr_dur), .len(len), .loop(loop), .start(start), .stop(stop),
    .busy(busy), .freq_out(freq_out), .gate(gate), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, got, expv);
    end
  endtask

  task automatic chk_evt(input evt_t got);
    evt_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL unexpected_event: observed kind=%0d cyc=%0d len=%0d freq=%0d idx=%0d expected none",
             got.kind, got.c, got.len, got.freq, got.idx);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        n_fail++;
        $error("FAIL event: observed kind=%0d cyc=%0d len=%0d freq=%0d idx=%0d expected kind=%0d cyc=%0d len=%0d freq=%0d idx=%0d",
               got.kind, got.c, got.len, got.freq, got.idx, e.kind, e.c, e.len, e.freq, e.idx);
      end
    end
  endtask

  task automatic push_note(input int c, input int l, input int f, input int i);
    evt_t e;
    e.kind = 2'd1; e.c = c; e.len = l; e.freq = f[11:0]; e.idx = i[3:0];
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c);
    evt_t e;
    e = '0; e.kind = 2'd2; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int a, input int f, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_freq = f[11:0]; wr_dur = d[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start is high during cycle t0; returns one cycle later.
  task automatic go(input int l, input logic lp);
    @(posedge clk); #1;
    len = l[4:0]; loop = lp; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: a gate high run becomes a note event, each done-high cycle a done event.
  initial begin
    logic gate_prev;
    int rise_c, rise_f, rise_i;
    evt_t ev;
    gate_prev = 1'b0; rise_c = 0; rise_f = 0; rise_i = 0;
    forever begin
      @(negedge clk);
      if (gate && !gate_prev) begin
        rise_c = cyc; rise_f = int'(freq_out); rise_i = int'(step_idx);
      end
      if (!gate && gate_prev) begin
        ev.kind = 2'd1; ev.c = rise_c; ev.len = cyc - rise_c;
        ev.freq = rise_f[11:0]; ev.idx = rise_i[3:0];
        chk_evt(ev);
      end
      if (done) begin
        ev = '0; ev.kind = 2'd2; ev.c = cyc;
        chk_evt(ev);
        chk("busy_low_at_done", int'(busy), 0);
      end
      gate_prev = gate;
    end
  end

  initial begin
    // Power-on reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_freq", int'(freq_out), 440);
    rst_n = 1'b1;

    // Two-note sequence
    wr(0, 440, 3); wr(1, 880, 1);
    go(2, 1'b0);
    push_note(t0 + 2, 30, 440, 0); push_note(t0 + 53, 10, 880, 1); push_done(t0 + 83);
    wait_cycle(t0 + 82); chk("seq_busy_before_done", int'(busy), 1);
    wait_cycle(t0 + 83); chk("seq_busy_at_done", int'(busy), 0);
    wait_cycle(t0 + 86);

    // Rest entry holds pitch with gate low
    wr(0, 523, 1); wr(1, 0, 2); wr(2, 659, 1);
    go(3, 1'b0);
    push_note(t0 + 2, 10, 523, 0); push_note(t0 + 74, 10, 659, 2); push_done(t0 + 104);
    wait_cycle(t0 + 40);
    chk("rest_freq_held", int'(freq_out), 523);
    chk("rest_gate", int'(gate), 0);
    chk("rest_step", int'(step_idx), 1);
    wait_cycle(t0 + 107);

    // Zero-duration entry is skipped in one LOAD cycle
    wr(0, 300, 1); wr(1, 500, 0); wr(2, 700, 1);
    go(3, 1'b0);
    push_note(t0 + 2, 10, 300, 0); push_note(t0 + 34, 10, 700, 2); push_done(t0 + 64);
    wait_cycle(t0 + 32); chk("skip_step1", int'(step_idx), 1);
    wait_cycle(t0 + 33); chk("skip_step2", int'(step_idx), 2);
    chk("skip_freq_untouched", int'(freq_out), 300);
    wait_cycle(t0 + 67);

    // Looping, then loop dropped before the second wrap
    wr(0, 440, 1); wr(1, 880, 1);
    go(2, 1'b1);
    push_note(t0 + 2, 10, 440, 0); push_note(t0 + 33, 10, 880, 1);
    push_note(t0 + 64, 10, 440, 0); push_note(t0 + 95, 10, 880, 1); push_done(t0 + 125);
    wait_cycle(t0 + 63);
    chk("loop_wrap_step", int'(step_idx), 0);
    chk("loop_wrap_busy", int'(busy), 1);
    wait_cycle(t0 + 80); loop = 1'b0;
    wait_cycle(t0 + 125); chk("loop_end_busy", int'(busy), 0);
    wait_cycle(t0 + 128);

    // Stop during NOTE
    wr(0, 600, 3);
    go(1, 1'b0);
    push_note(t0 + 2, 9, 600, 0);
    wait_cycle(t0 + 10); chk("stop_gate_before", int'(gate), 1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_gate", int'(gate), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_freq_held", int'(freq_out), 600);
    chk("stop_step_held", int'(step_idx), 0);
    wait_cycle(t0 + 14); chk("stop_no_done", int'(done), 0);

    // Start while busy is ignored
    wr(0, 440, 1);
    go(1, 1'b0);
    push_note(t0 + 2, 10, 440, 0); push_done(t0 + 32);
    wait_cycle(t0 + 5);
    len = 5'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cycle(t0 + 32); chk("busy_start_ignored", int'(busy), 0);
    wait_cycle(t0 + 35);

    // len == 0 pulses done without becoming busy
    go(0, 1'b0);
    push_done(t0 + 1);
    wait_cycle(t0 + 1); chk("len0_busy", int'(busy), 0);
    wait_cycle(t0 + 2); chk("len0_busy_after", int'(busy), 0);
    wait_cycle(t0 + 4);

    // Start together with stop in IDLE is ignored
    @(posedge clk); #1;
    len = 5'd1; start = 1'b1; stop = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    wait_cycle(t0 + 3);
    chk("startstop_busy_later", int'(busy), 0);
    chk("startstop_gate", int'(gate), 0);

    // Reset mid-NOTE on entry 1
    wr(0, 123, 0); wr(1, 1000, 3);
    go(2, 1'b0);
    push_note(t0 + 3, 7, 1000, 1);
    wait_cycle(t0 + 9);
    chk("pre_reset_freq", int'(freq_out), 1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_freq", int'(freq_out), 440);
    chk("async_rst_gate", int'(gate), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_step", int'(step_idx), 0);
    wait_cycle(t0 + 11);
    chk("rst_next_freq", int'(freq_out), 440);
    chk("rst_next_gate", int'(gate), 0);
    chk("rst_next_busy", int'(busy), 0);
    chk("rst_next_step", int'(step_idx), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
